// File: rtl/psg_sn76489.sv
// SN76489AN-compatible programmable sound generator.
// Three square-wave tone channels, one LFSR noise channel, 4-bit
// attenuation per channel and a registered digital mix for the board DAC.
// CPU writes arrive one byte per wr strobe and are applied on the edge that
// samples wr; all audio timing advances on the ce chip-clock enable.
module psg_sn76489 #(
  parameter int OUT_BITS = 10
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                ce,
  input  logic                wr,
  input  logic [7:0]          din,
  output logic [OUT_BITS-1:0] audio_out,
  output logic [3:0]          ch_active
);

  localparam logic [14:0] LFSR_SEED = 15'h4000;

  // Attenuation code to linear amplitude; code 15 is silence.
  function automatic logic [7:0] amp_lut(input logic [3:0] att);
    logic [7:0] a;
    case (att)
      4'd0:    a = 8'd255;
      4'd1:    a = 8'd203;
      4'd2:    a = 8'd161;
      4'd3:    a = 8'd128;
      4'd4:    a = 8'd102;
      4'd5:    a = 8'd81;
      4'd6:    a = 8'd64;
      4'd7:    a = 8'd51;
      4'd8:    a = 8'd40;
      4'd9:    a = 8'd32;
      4'd10:   a = 8'd26;
      4'd11:   a = 8'd20;
      4'd12:   a = 8'd16;
      4'd13:   a = 8'd13;
      4'd14:   a = 8'd10;
      default: a = 8'd0;
    endcase
    return a;
  endfunction

  // Register file
  logic [9:0]  r_tone_per [3];
  logic [3:0]  r_atten    [4];
  logic [2:0]  r_noise_ctl;
  logic [2:0]  r_latch;

  // Timing state
  logic [3:0]  r_presc;
  logic [9:0]  r_cnt [3];
  logic [2:0]  r_sq;
  logic [6:0]  r_ncnt;
  logic        r_nsrc;
  logic        r_nsrc_prev;
  logic [14:0] r_lfsr;

  // Output registers
  logic [OUT_BITS-1:0] r_audio;
  logic [3:0]          r_active;

  // Write decode: a latch byte carries its own channel/type, a data byte
  // reuses the most recently latched channel/type.
  logic [1:0] w_chan;
  logic       w_type;
  logic       w_wr_noise;
  logic       w_tick;
  logic [6:0] w_nreload;
  logic       w_nsrc;
  logic       w_nedge;
  logic       w_nfb;
  logic [3:0] w_out;
  logic [3:0] w_act;
  logic [OUT_BITS-1:0] w_mix;

  assign w_chan     = din[7] ? din[6:5] : r_latch[2:1];
  assign w_type     = din[7] ? din[4]   : r_latch[0];
  assign w_wr_noise = wr && !w_type && (w_chan == 2'd3);

  // The prescaler divides ce by 16 to produce the tone/noise tick.
  assign w_tick = ce && (r_presc == 4'hF);

  // Rate 11 clocks the noise from tone 2; otherwise from its own divider.
  assign w_nsrc  = (r_noise_ctl[1:0] == 2'b11) ? r_sq[2] : r_nsrc;
  assign w_nedge = w_nsrc && !r_nsrc_prev;
  assign w_nfb   = r_noise_ctl[2] ? (r_lfsr[0] ^ r_lfsr[1]) : r_lfsr[0];

  assign w_out = {r_lfsr[0], r_sq[2], r_sq[1], r_sq[0]};

  // Noise divider reload value for the three fixed rates.
  always_comb begin
    w_nreload = 7'd64;
    case (r_noise_ctl[1:0])
      2'b00:   w_nreload = 7'd16;
      2'b01:   w_nreload = 7'd32;
      default: w_nreload = 7'd64;
    endcase
  end

  // Per-channel gated amplitude sum and activity flags.
  always_comb begin
    w_mix = '0;
    w_act = '0;
    for (int n = 0; n < 4; n++) begin
      if (w_out[n]) begin
        w_mix = w_mix + OUT_BITS'(amp_lut(r_atten[n]));
      end
      w_act[n] = w_out[n] && (r_atten[n] != 4'hF);
    end
  end

  // CPU register writes: latch, attenuation, tone period halves, noise control.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_latch     <= 3'b000;
      r_noise_ctl <= 3'b000;
      for (int n = 0; n < 3; n++) r_tone_per[n] <= 10'd0;
      for (int n = 0; n < 4; n++) r_atten[n] <= 4'hF;
    end else if (wr) begin
      if (din[7]) begin
        r_latch <= din[6:4];
      end
      if (w_type) begin
        case (w_chan)
          2'd0:    r_atten[0] <= din[3:0];
          2'd1:    r_atten[1] <= din[3:0];
          2'd2:    r_atten[2] <= din[3:0];
          default: r_atten[3] <= din[3:0];
        endcase
      end else begin
        case (w_chan)
          2'd0: begin
            if (din[7]) r_tone_per[0][3:0] <= din[3:0];
            else        r_tone_per[0][9:4] <= din[5:0];
          end
          2'd1: begin
            if (din[7]) r_tone_per[1][3:0] <= din[3:0];
            else        r_tone_per[1][9:4] <= din[5:0];
          end
          2'd2: begin
            if (din[7]) r_tone_per[2][3:0] <= din[3:0];
            else        r_tone_per[2][9:4] <= din[5:0];
          end
          default: r_noise_ctl <= din[2:0];
        endcase
      end
    end
  end

  // Free-running ce/16 prescaler.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_presc <= 4'd0;
    end else if (ce) begin
      r_presc <= r_presc + 4'd1;
    end
  end

  // Tone counters: reload from the period register only when the count
  // expires, so a period write never truncates the half-period in flight.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_sq <= 3'b000;
      for (int n = 0; n < 3; n++) r_cnt[n] <= 10'd0;
    end else if (w_tick) begin
      for (int n = 0; n < 3; n++) begin
        if (r_cnt[n] == 10'd1) begin
          r_cnt[n] <= r_tone_per[n];
          r_sq[n]  <= ~r_sq[n];
        end else begin
          r_cnt[n] <= r_cnt[n] - 10'd1;
        end
      end
    end
  end

  // Noise rate divider; a noise-control write restarts it from zero.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_ncnt <= 7'd0;
      r_nsrc <= 1'b0;
    end else if (w_wr_noise) begin
      r_ncnt <= 7'd0;
    end else if (w_tick && (r_noise_ctl[1:0] != 2'b11)) begin
      if (r_ncnt == 7'd1) begin
        r_ncnt <= w_nreload;
        r_nsrc <= ~r_nsrc;
      end else begin
        r_ncnt <= r_ncnt - 7'd1;
      end
    end
  end

  // LFSR shifts on each rising edge of the noise source. A control write
  // reseeds it and forces the edge detector high so that switching the
  // source cannot fabricate a spurious edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_lfsr      <= LFSR_SEED;
      r_nsrc_prev <= 1'b0;
    end else if (w_wr_noise) begin
      r_lfsr      <= LFSR_SEED;
      r_nsrc_prev <= 1'b1;
    end else begin
      r_nsrc_prev <= w_nsrc;
      if (w_nedge) begin
        r_lfsr <= {w_nfb, r_lfsr[14:1]};
      end
    end
  end

  // Registered mix and activity flags, refreshed on every chip clock.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_audio  <= '0;
      r_active <= 4'b0000;
    end else if (ce) begin
      r_audio  <= w_mix;
      r_active <= w_act;
    end
  end

  assign audio_out = r_audio;
  assign ch_active = r_active;

endmodule

// File: doc/psg_sn76489.md
# psg_sn76489

SN76489AN-compatible programmable sound generator: three square-wave tone channels, one noise channel, 4-bit attenuation per channel, digital mix. It is the receiving end of the CPU's sound-port writes (I/O port 0xFF decode, one byte per `wr` strobe). It replaces the constant-zero audio in the ColecoVision top level. The mix drives the board audio DAC.

## Interface
Parameters:
- `OUT_BITS`, default 10: width of `audio_out`. Fixed at 10; any other value is unsupported.

Ports:
- `clk`  in  1  system clock (`cpuClock`, 25 MHz)
- `reset_n`  in  1  asynchronous, active-low reset
- `ce`  in  1  chip clock enable, one-`clk` pulse at ~3.58 MHz (`cpuClockEdge`)
- `wr`  in  1  write strobe, one `clk` wide; sampled on any `clk` edge, independent of `ce`
- `din`  in  8  write data (`cpuDataOut`)
- `audio_out`  out  10  unsigned mix of the 4 channels, registered
- `ch_active`  out  4  per-channel output-high AND attenuation≠15 (diag/LEDs), registered

## Operation
- Register file:
  - `tone_per[0..2]`: 10 bits
  - `atten[0..3]`: 4 bits
  - `noise_ctl`: 3 bits, bit2 = white, bits1:0 = rate
  - `latch`: 3 bits = {chan[1:0], type}
- Latch byte (`din[7]=1`):
  - `latch <= din[6:4]`.
  - type=1: `atten[chan] <= din[3:0]`.
  - type=0, chan 0-2: `tone_per[chan][3:0] <= din[3:0]`.
  - type=0, chan 3: `noise_ctl <= din[2:0]`, LFSR <= 15'h4000, noise counter <= 0.
- Data byte (`din[7]=0`):
  - Latched tone (chan 0-2, type 0): `tone_per[chan][9:4] <= din[5:0]`.
  - Latched volume or noise: same effect as a latch byte with `din[3:0]`, including the LFSR reset for noise.
- Prescaler: 4-bit counter advanced on `ce`. `tick` = `ce` && prescaler==15, i.e. `ce`/16.
- Tone channel n:
  - 10-bit counter `cnt`, output bit `sq`.
  - On `tick`: if `cnt==1`, then `cnt <= tone_per[n]` and `sq` toggles; else `cnt <= cnt-1` (10-bit wrap).
  - Result: period 1 toggles every tick; period 0 behaves as 1024.
- Noise channel:
  - Rate 00/01/10: 7-bit counter with reload 16/32/64, same decrement rule, toggles `nsrc`.
  - Rate 11: `nsrc` follows tone 2's `sq`.
  - On each 0→1 edge of `nsrc`: LFSR shifts right; new bit14 = white ? (bit0 ^ bit1) : bit0.
  - Noise output = LFSR bit0.
- Amplitude table, attenuation 0..15: 255,203,161,128,102,81,64,51,40,32,26,20,16,13,10,0.
- Mix: on every `ce`, `audio_out <= Σ (out_n ? amp[atten_n] : 0)`. Maximum 1020, so no overflow in 10 bits.

## Timing
- Reset values:
  - All `tone_per` = 0; all `atten` = 15 (silent); `noise_ctl` = 0; `latch` = 3'b000.
  - Prescaler, all `cnt` = 0; all `sq` = 0; LFSR = 15'h4000.
  - `audio_out` = 0; `ch_active` = 0.
- Reset is asynchronous. Asserting it mid-tone silences the output immediately: `audio_out` = 0 while `reset_n` = 0.
- Write latency: the register is updated on the `clk` edge that samples `wr`. The new attenuation is visible in `audio_out` at the next `ce`.
- `wr` and `tick` on the same edge: a reload occurring on that edge uses the old `tone_per`; the new value is used from the next reload. The running `cnt` is never truncated.
- A noise-control write on the same edge as an LFSR shift: the reset to 15'h4000 wins.
- Back-to-back `wr` on consecutive `clk` cycles are each applied in order. No handshake and no busy state.
- First toggle after reset: channel n toggles after 1024 ticks, because cnt=0 wraps to 1023.

## Test plan
- Reset, then no writes -> `audio_out`=0 and `ch_active`=0 for 100k `clk`.
- Write 8'h85, 8'h00, 8'h90 (ch0 period 5, atten 0) -> after the first reload, `audio_out` alternates 255/0 every 5 ticks (80 `ce`).
- Write 8'h9F mid-tone -> `audio_out`=0 from the next `ce`. Then write 8'h98 -> high level becomes 40.
- Write 8'hE4 (white, rate 00) then 8'hF0 -> LFSR reloads 15'h4000. The bit0 sequence matches the reference 15-bit model with taps 0^1 at one shift per 32 ticks. A periodic-mode write (8'hE0) repeats every 15 shifts.
- All four channels at atten 0 with outputs high -> `audio_out`=1020 with no wrap. Period 0 on ch1 -> toggles every 1024 ticks.
- `wr` coincident with the tick that reloads ch0 (period 5→3) -> the following half-period is 5 ticks, then 3.
